// File: rtl/x16_bus_pkg.sv
// rtl/x16_bus_pkg.sv - X16 bus register map, bit indices and shared helpers
package x16_bus_pkg;

    localparam logic [4:0] REG_DATA   = 5'h00;
    localparam logic [4:0] REG_STATUS = 5'h01;
    localparam logic [4:0] REG_COUNT  = 5'h02;
    localparam logic [4:0] REG_CTRL   = 5'h03;
    localparam logic [4:0] REG_THRESH = 5'h04;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UDF   = 3;
    localparam int ST_THR   = 4;
    localparam int ST_IRQ   = 7;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam logic RWB_WRITE = 1'b1;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    // Only a 256-deep FIFO can exceed the 8-bit COUNT register
    function automatic logic [7:0] sat_count(input logic [8:0] c);
        return (c > 9'd255) ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/x16_sync_fifo.sv
// rtl/x16_sync_fifo.sv - single-port byte FIFO with AW+1 bit wrap pointers
module x16_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !reset && !flush)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/x16_fifo_target.sv
// rtl/x16_fifo_target.sv - X16 bus target exposing a byte FIFO through a 32-byte register window
module x16_fifo_target
    import x16_bus_pkg::*;
#(
    parameter int         DEPTH        = 16,
    parameter int         AW           = 4,
    parameter logic [7:0] THRESH_RESET = 8'd8
) (
    input  logic       PHI2,
    input  logic       RESET,
    input  logic       CS,
    input  logic       RWB,
    input  logic [4:0] addr,
    inout  wire  [7:0] data,
    output logic       IRQ
);

    phase_t      phase;
    phase_t      phase_next;
    logic [AW:0] count;
    logic [8:0]  count_ext;
    logic [7:0]  dout;
    logic [7:0]  rdata;
    logic [7:0]  thresh;
    logic        empty, full, ovf, udf, irq_en, at_thr;
    logic        wr_stb, rd_stb, push, pop, ctrl_wr, flush;

    always_ff @(posedge PHI2) begin
        if (RESET)
            phase <= PH_A;
        else
            phase <= phase_next;
    end

    always_comb begin
        phase_next = PH_A;
        if (CS)
            phase_next = (phase == PH_A) ? PH_B : PH_A;
    end

    // Side effects only at the edge closing phase B; dropping CS in phase A aborts cleanly
    assign wr_stb  = CS && (phase == PH_B) && (RWB == RWB_WRITE);
    assign rd_stb  = CS && (phase == PH_B) && (RWB != RWB_WRITE);
    assign push    = wr_stb && (addr == REG_DATA);
    assign pop     = rd_stb && (addr == REG_DATA);
    assign ctrl_wr = wr_stb && (addr == REG_CTRL);
    assign flush   = ctrl_wr && data[CTRL_FLUSH];

    x16_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (PHI2),
        .reset (RESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (data),
        .dout  (dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign count_ext = 9'(count);
    assign at_thr    = (count_ext >= {1'b0, thresh});

    always_ff @(posedge PHI2) begin
        if (RESET) begin
            ovf    <= 1'b0;
            udf    <= 1'b0;
            irq_en <= 1'b0;
            thresh <= THRESH_RESET;
            IRQ    <= 1'b0;
        end else begin
            // Clear first so a coincident set wins
            if (ctrl_wr && data[CTRL_CLR]) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            if (push && full)
                ovf <= 1'b1;
            if (pop && empty)
                udf <= 1'b1;
            if (ctrl_wr)
                irq_en <= data[CTRL_IRQ_EN];
            if (wr_stb && (addr == REG_THRESH))
                thresh <= data;
            IRQ <= irq_en && (at_thr || ovf || udf);
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            REG_DATA:   rdata = empty ? 8'h00 : dout;
            REG_STATUS: begin
                rdata[ST_EMPTY] = empty;
                rdata[ST_FULL]  = full;
                rdata[ST_OVF]   = ovf;
                rdata[ST_UDF]   = udf;
                rdata[ST_THR]   = at_thr;
                rdata[ST_IRQ]   = IRQ;
            end
            REG_COUNT:  rdata = sat_count(count_ext);
            REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
            REG_THRESH: rdata = thresh;
            default:    rdata = 8'h00;
        endcase
    end

    assign data = (CS && (RWB != RWB_WRITE) && !RESET) ? rdata : 8'hzz;

endmodule

// File: tb/tb_x16_fifo_target.sv
// tb/tb_x16_fifo_target.sv - self-checking bench for x16_fifo_target
module tb_x16_fifo_target;

    logic       PHI2;
    logic       RESET;
    logic       CS;
    logic       RWB;
    logic [4:0] addr;
    wire  [7:0] data;
    logic       IRQ;
    logic [7:0] tb_data;
    logic       tb_drive;

    int n_checks;
    int n_fail;

    assign data = tb_drive ? tb_data : 8'hzz;

    x16_fifo_target #(.DEPTH(16), .AW(4), .THRESH_RESET(8'd8)) dut (
        .PHI2  (PHI2),
        .RESET (RESET),
        .CS    (CS),
        .RWB   (RWB),
        .addr  (addr),
        .data  (data),
        .IRQ   (IRQ)
    );

    initial begin
        PHI2 = 1'b0;
        forever #5 PHI2 = ~PHI2;
    end

    typedef struct {
        bit         wr;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vt[$];

    function automatic void add_vec(bit wr, logic [4:0] a, logic [7:0] d, logic [7:0] exp, string name);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp = exp; v.name = name;
        vt.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a negedge
    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        CS = 1'b1; RWB = 1'b1; addr = a; tb_data = d; tb_drive = 1'b1;
        @(posedge PHI2);
        @(posedge PHI2);
        @(negedge PHI2);
        CS = 1'b0; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
        CS = 1'b1; RWB = 1'b0; addr = a; tb_drive = 1'b0;
        @(posedge PHI2);
        @(negedge PHI2);
        d = data;
        @(posedge PHI2);
        @(negedge PHI2);
        CS = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PHI2);
            @(negedge PHI2);
        end
    endtask

    // Reference model state
    byte unsigned m_q[$];
    logic [7:0]   m_thresh;
    bit           m_irq_en, m_ovf, m_udf;

    function automatic bit m_irq();
        return m_irq_en && ((m_q.size() >= int'(m_thresh)) || m_ovf || m_udf);
    endfunction

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (m_q.size() == 0);
        s[1] = (m_q.size() == 16);
        s[2] = m_ovf;
        s[3] = m_udf;
        s[4] = (m_q.size() >= int'(m_thresh));
        s[7] = m_irq();
        return s;
    endfunction

    initial begin
        logic [7:0] rd;
        logic [7:0] exp;
        logic [4:0] a;
        n_checks = 0;
        n_fail   = 0;
        RESET = 1'b1; CS = 1'b0; RWB = 1'b0; addr = 5'h00; tb_data = 8'h00; tb_drive = 1'b0;
        repeat (3) @(posedge PHI2);
        @(negedge PHI2);
        RESET = 1'b0;
        @(negedge PHI2);

        check("reset_irq", {7'b0, IRQ}, 8'h00);
        // Bench drives 0 on the bus with CS low; any DUT drive of STATUS (0x01) would show
        tb_drive = 1'b1; tb_data = 8'h00; RWB = 1'b0; addr = 5'h01;
        #1 check("hiz_cs_low", data, 8'h00);
        tb_drive = 1'b0;

        add_vec(0, 5'h01, 8'h00, 8'h01, "t1_status");
        add_vec(0, 5'h02, 8'h00, 8'h00, "t1_count");
        add_vec(0, 5'h04, 8'h00, 8'h08, "t1_thresh");
        add_vec(0, 5'h03, 8'h00, 8'h00, "t1_ctrl");
        add_vec(1, 5'h00, 8'h11, 8'h00, "");
        add_vec(1, 5'h00, 8'h22, 8'h00, "");
        add_vec(1, 5'h00, 8'h33, 8'h00, "");
        add_vec(0, 5'h02, 8'h00, 8'h03, "t2_count3");
        add_vec(0, 5'h00, 8'h00, 8'h11, "t2_pop0");
        add_vec(0, 5'h00, 8'h00, 8'h22, "t2_pop1");
        add_vec(0, 5'h00, 8'h00, 8'h33, "t2_pop2");
        add_vec(0, 5'h02, 8'h00, 8'h00, "t2_count0");
        add_vec(0, 5'h01, 8'h00, 8'h01, "t2_status");
        for (int i = 0; i <= 16; i++)
            add_vec(1, 5'h00, 8'(i), 8'h00, "");
        add_vec(0, 5'h02, 8'h00, 8'h10, "t3_count_full");
        add_vec(0, 5'h01, 8'h00, 8'h16, "t3_status_full");
        for (int i = 0; i < 16; i++)
            add_vec(0, 5'h00, 8'h00, 8'(i), $sformatf("t3_pop%0d", i));
        add_vec(0, 5'h01, 8'h00, 8'h05, "t3_status_drained");
        add_vec(0, 5'h00, 8'h00, 8'h00, "t4_pop_empty");
        add_vec(0, 5'h01, 8'h00, 8'h0D, "t4_status_udf");
        add_vec(1, 5'h01, 8'hFF, 8'h00, "");
        add_vec(1, 5'h03, 8'h02, 8'h00, "");
        add_vec(0, 5'h01, 8'h00, 8'h01, "t4_status_cleared");
        add_vec(0, 5'h1F, 8'h00, 8'h00, "t4_unmapped");

        foreach (vt[i]) begin
            if (vt[i].wr)
                bus_write(vt[i].a, vt[i].d);
            else begin
                bus_read(vt[i].a, rd);
                check(vt[i].name, rd, vt[i].exp);
            end
        end

        bus_write(5'h03, 8'h04);
        bus_read(5'h03, rd);
        check("t5_ctrl", rd, 8'h04);
        bus_write(5'h04, 8'h04);
        bus_read(5'h04, rd);
        check("t5_thresh", rd, 8'h04);
        for (int i = 0; i < 4; i++)
            bus_write(5'h00, 8'h40 + 8'(i));
        check("t5_irq_not_yet", {7'b0, IRQ}, 8'h00);
        idle(1);
        check("t5_irq_rise", {7'b0, IRQ}, 8'h01);
        bus_read(5'h00, rd);
        check("t5_pop_val", rd, 8'h40);
        check("t5_irq_still", {7'b0, IRQ}, 8'h01);
        idle(1);
        check("t5_irq_fall", {7'b0, IRQ}, 8'h00);
        bus_write(5'h00, 8'h44);
        idle(1);
        check("t5_irq_again", {7'b0, IRQ}, 8'h01);
        bus_write(5'h03, 8'h05);
        idle(1);
        check("t5_irq_flush", {7'b0, IRQ}, 8'h00);
        bus_read(5'h02, rd);
        check("t5_count_flush", rd, 8'h00);
        bus_write(5'h04, 8'h00);
        idle(1);
        check("t5_thresh0_irq", {7'b0, IRQ}, 8'h01);
        bus_write(5'h03, 8'h00);
        bus_write(5'h04, 8'h08);
        idle(1);
        check("t5_irq_off", {7'b0, IRQ}, 8'h00);

        for (int i = 0; i < 8; i++)
            bus_write(5'h00, 8'hA0 + 8'(i));
        CS = 1'b1; RWB = 1'b0; addr = 5'h00;
        for (int k = 0; k < 8; k++) begin
            @(posedge PHI2);
            @(negedge PHI2);
            check($sformatf("t6_stream%0d", k), data, 8'hA0 + 8'((k + 1) / 2));
        end
        CS = 1'b0;
        bus_read(5'h02, rd);
        check("t6_count4", rd, 8'h04);
        bus_read(5'h00, rd);
        check("t6_next", rd, 8'hA4);
        CS = 1'b1; RWB = 1'b0; addr = 5'h00;
        @(posedge PHI2);
        @(negedge PHI2);
        RESET = 1'b1;
        tb_drive = 1'b1; tb_data = 8'h00;
        #1 check("t6_hiz_reset", data, 8'h00);
        tb_drive = 1'b0;
        @(posedge PHI2);
        @(negedge PHI2);
        RESET = 1'b0; CS = 1'b0;
        idle(1);
        bus_read(5'h02, rd);
        check("t6_count_reset", rd, 8'h00);
        bus_read(5'h01, rd);
        check("t6_status_reset", rd, 8'h01);
        bus_read(5'h04, rd);
        check("t6_thresh_reset", rd, 8'h08);
        check("t6_irq_reset", {7'b0, IRQ}, 8'h00);

        m_q.delete();
        m_thresh = 8'd8; m_irq_en = 0; m_ovf = 0; m_udf = 0;
        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 11);
            case (op)
                0, 1, 2, 3: begin
                    exp = 8'($urandom);
                    bus_write(5'h00, exp);
                    if (m_q.size() == 16) m_ovf = 1;
                    else m_q.push_back(exp);
                end
                4, 5, 6: begin
                    bus_read(5'h00, rd);
                    if (m_q.size() == 0) begin
                        m_udf = 1;
                        exp = 8'h00;
                    end else
                        exp = m_q.pop_front();
                    check("rnd_data", rd, exp);
                end
                7: begin
                    exp = m_status();
                    bus_read(5'h01, rd);
                    check("rnd_status", rd, exp);
                    bus_read(5'h02, rd);
                    check("rnd_count", rd, 8'(m_q.size()));
                end
                8: begin
                    exp = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) exp[0] = 1'b0;
                    bus_write(5'h03, exp);
                    if (exp[0]) m_q.delete();
                    if (exp[1]) begin m_ovf = 0; m_udf = 0; end
                    m_irq_en = exp[2];
                end
                9: begin
                    m_thresh = 8'($urandom_range(0, 18));
                    bus_write(5'h04, m_thresh);
                end
                10: begin
                    bus_read(5'h03, rd);
                    check("rnd_ctrl", rd, {5'b0, m_irq_en, 2'b0});
                    bus_read(5'h04, rd);
                    check("rnd_thresh", rd, m_thresh);
                end
                default: begin
                    a = 5'($urandom_range(5, 31));
                    if ($urandom_range(0, 1) == 0) a = 5'($urandom_range(1, 2));
                    bus_write(a, 8'($urandom));
                    bus_read(a, rd);
                    exp = (a == 5'h01) ? m_status() : (a == 5'h02) ? 8'(m_q.size()) : 8'h00;
                    check("rnd_ignored", rd, exp);
                end
            endcase
            idle(1);
            check("rnd_irq", {7'b0, IRQ}, {7'b0, m_irq()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
